fp_addsub: RTL and testbench

- Single-precision IEEE-754 (binary32) floating-point adder/subtractor with a start/done handshake.
- Computes op1+op2 or op1−op2 in one clock and registers the result.
- Sits as the add/sub execution unit beside other FP arithmetic blocks. Flags exponent overflow.

---
 rtl/fp_addsub.sv | 166 ++++++++++++++++
 tb/tb_fp_addsub.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub.sv
// Single-precision (binary32) adder/subtractor. The datapath is one combinational stage whose result is captured on add_start.
// Build option ADDSUB_RNE_EN: when defined, round to nearest even; otherwise truncate toward zero.
module fp_addsub (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        add_start,
    input  logic        mode,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] add_result,
    output logic        add_done,
    output logic        add_overflow
);

    localparam logic [31:0] QNAN   = 32'h7FC00000;
    localparam logic [26:0] ONES27 = '1;

`ifdef ADDSUB_RNE_EN
    localparam logic RNE_EN = 1'b1;
`else
    localparam logic RNE_EN = 1'b0;
`endif

    logic        sign_x, sign_y;
    logic [7:0]  exp_x, exp_y;
    logic [22:0] frac_x, frac_y;
    logic        nan_x, nan_y, inf_x, inf_y, zero_x, zero_y;

    logic        swap;
    logic        sign_a, sign_b, eff_sub;
    logic [7:0]  exp_a, exp_b, exp_diff;
    logic [22:0] frac_a, frac_b;
    logic [26:0] mant_a, mant_b, mant_b_al;

    logic [27:0] sum_ab;
    logic [26:0] diff_ab;
    logic [4:0]  lzc;
    logic        lzc_found;

    logic [26:0] mant_n;
    logic [9:0]  exp_n, exp_f;
    logic        round_up;
    logic [24:0] mant_r;
    logic [22:0] frac_f;

    logic [31:0] result_d, result_q;
    logic        ovf_d, ovf_q;
    logic        done_q;

    // Operand B's sign is flipped for subtraction so the rest of the datapath only adds.
    assign sign_x = op1[31];
    assign exp_x  = op1[30:23];
    assign frac_x = op1[22:0];
    assign sign_y = op2[31] ^ mode;
    assign exp_y  = op2[30:23];
    assign frac_y = op2[22:0];

    assign nan_x  = (exp_x == 8'hFF) && (frac_x != 23'd0);
    assign nan_y  = (exp_y == 8'hFF) && (frac_y != 23'd0);
    assign inf_x  = (exp_x == 8'hFF) && (frac_x == 23'd0);
    assign inf_y  = (exp_y == 8'hFF) && (frac_y == 23'd0);
    assign zero_x = (exp_x == 8'd0);
    assign zero_y = (exp_y == 8'd0);

    assign swap   = {exp_y, frac_y} > {exp_x, frac_x};
    assign sign_a = swap ? sign_y : sign_x;
    assign exp_a  = swap ? exp_y  : exp_x;
    assign frac_a = swap ? frac_y : frac_x;
    assign sign_b = swap ? sign_x : sign_y;
    assign exp_b  = swap ? exp_x  : exp_y;
    assign frac_b = swap ? frac_x : frac_y;

    assign eff_sub  = sign_a ^ sign_b;
    assign exp_diff = exp_a - exp_b;
    assign mant_a   = {1'b1, frac_a, 3'b000};
    assign mant_b   = {1'b1, frac_b, 3'b000};

    // Bits shifted past the round position are folded into the sticky LSB.
    always_comb begin
        if (exp_diff >= 8'd27) begin
            mant_b_al = 27'd1;
        end else begin
            mant_b_al = (mant_b >> exp_diff)
                      | {26'd0, |(mant_b & ~(ONES27 << exp_diff))};
        end
    end

    assign sum_ab  = {1'b0, mant_a} + {1'b0, mant_b_al};
    assign diff_ab = mant_a - mant_b_al;

    always_comb begin
        lzc       = 5'd0;
        lzc_found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!lzc_found && diff_ab[i]) begin
                lzc       = 5'(26 - i);
                lzc_found = 1'b1;
            end
        end
    end

    always_comb begin
        if (eff_sub) begin
            mant_n = diff_ab << lzc;
            exp_n  = {2'b00, exp_a} - {5'd0, lzc};
        end else if (sum_ab[27]) begin
            mant_n = {sum_ab[27:2], sum_ab[1] | sum_ab[0]};
            exp_n  = {2'b00, exp_a} + 10'd1;
        end else begin
            mant_n = sum_ab[26:0];
            exp_n  = {2'b00, exp_a};
        end
    end

    // mant_n[3] is the result LSB; [2:0] are guard, round and sticky.
    assign round_up = RNE_EN & mant_n[2] & (mant_n[1] | mant_n[0] | mant_n[3]);
    assign mant_r   = {1'b0, mant_n[26:3]} + {24'd0, round_up};
    assign frac_f   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    assign exp_f    = mant_r[24] ? (exp_n + 10'd1) : exp_n;

    always_comb begin
        result_d = 32'h0;
        ovf_d    = 1'b0;
        if (nan_x || nan_y || (inf_x && inf_y && (sign_x != sign_y))) begin
            result_d = QNAN;
        end else if (inf_x) begin
            result_d = {sign_x, 8'hFF, 23'd0};
        end else if (inf_y) begin
            result_d = {sign_y, 8'hFF, 23'd0};
        end else if (zero_x && zero_y) begin
            result_d = {sign_x & sign_y, 31'd0};
        end else if (zero_x) begin
            result_d = {sign_y, exp_y, frac_y};
        end else if (zero_y) begin
            result_d = {sign_x, exp_x, frac_x};
        end else if (eff_sub && (diff_ab == 27'd0)) begin
            result_d = 32'h0;
        end else if (exp_n[9] || (exp_n == 10'd0)) begin
            result_d = {sign_a, 31'd0};
        end else if (exp_f >= 10'd255) begin
            result_d = {sign_a, 8'hFF, 23'd0};
            ovf_d    = 1'b1;
        end else begin
            result_d = {sign_a, exp_f[7:0], frac_f};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            result_q <= 32'h0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else if (add_start) begin
            result_q <= result_d;
            ovf_q    <= ovf_d;
            done_q   <= 1'b1;
        end else begin
            done_q   <= 1'b0;
        end
    end

    assign add_result   = result_q;
    assign add_overflow = ovf_q;
    assign add_done     = done_q;

endmodule

// File: tb/tb_fp_addsub.sv
// Testbench for fp_addsub: directed vectors, handshake and reset scenarios, and randomized operands
// checked against an exact wide-integer reference model.
module tb_fp_addsub;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        add_start;
    logic        mode;
    logic [31:0] op1, op2;
    logic [31:0] add_result;
    logic        add_done;
    logic        add_overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fp_addsub dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .add_start    (add_start),
        .mode         (mode),
        .op1          (op1),
        .op2          (op2),
        .add_result   (add_result),
        .add_done     (add_done),
        .add_overflow (add_overflow)
    );

`ifdef ADDSUB_RNE_EN
    localparam logic [31:0] TIE_EXP = 32'h3F800002;
`else
    localparam logic [31:0] TIE_EXP = 32'h3F800001;
`endif

    localparam int N_DIR = 14;
    localparam logic [31:0] DIR_A [N_DIR] = '{
        32'h40200000, 32'h40300000, 32'hC61C4238, 32'hC61C4238, 32'h40840000,
        32'hC0840000, 32'h40600000, 32'h41480000, 32'h418C0000, 32'h7F7FFFFF,
        32'h7F800000, 32'h80000000, 32'h00000000, 32'h3F800001};
    localparam logic [31:0] DIR_B [N_DIR] = '{
        32'h40600000, 32'h40300000, 32'hC61C4238, 32'h461C4238, 32'hC0800000,
        32'h40800000, 32'h40200000, 32'h418C0000, 32'h41480000, 32'h7F7FFFFF,
        32'hFF800000, 32'h80000000, 32'h3F800000, 32'h33800000};
    localparam logic        DIR_M [N_DIR] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [31:0] DIR_R [N_DIR] = '{
        32'h40C00000, 32'h40B00000, 32'hC69C4238, 32'h00000000, 32'h3E000000,
        32'hBE000000, 32'h3F800000, 32'h41F00000, 32'h41F00000, 32'h7F800000,
        32'h7FC00000, 32'h80000000, 32'hBF800000, TIE_EXP};
    localparam logic        DIR_O [N_DIR] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Exact reference: each operand becomes an integer in units of 2^-149, summed at full width, then rounded once.
    function automatic logic [32:0] ref_addsub(input logic [31:0] a, input logic [31:0] b, input logic m);
        logic         sa, sb, s, found;
        logic [7:0]   ea, eb;
        logic [22:0]  fa, fb;
        logic [319:0] ma, mb, mag;
        logic [24:0]  mant;
        int           p, e, sh;
`ifdef ADDSUB_RNE_EN
        logic [319:0] rem, half;
`endif
        sa = a[31]; ea = a[30:23]; fa = a[22:0];
        sb = b[31] ^ m; eb = b[30:23]; fb = b[22:0];
        if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0) ||
            (ea == 8'hFF && eb == 8'hFF && sa != sb))
            return {1'b0, 32'h7FC00000};
        if (ea == 8'hFF) return {1'b0, sa, 8'hFF, 23'd0};
        if (eb == 8'hFF) return {1'b0, sb, 8'hFF, 23'd0};
        if (ea == 0 && eb == 0) return {1'b0, sa & sb, 31'd0};
        if (ea == 0) return {1'b0, sb, eb, fb};
        if (eb == 0) return {1'b0, sa, ea, fa};
        ma = {296'd0, 1'b1, fa} << (int'(ea) - 1);
        mb = {296'd0, 1'b1, fb} << (int'(eb) - 1);
        if (sa == sb) begin
            mag = ma + mb; s = sa;
        end else if (ma >= mb) begin
            mag = ma - mb; s = sa;
        end else begin
            mag = mb - ma; s = sb;
        end
        if (mag == 0) return 33'd0;
        p = 0; found = 1'b0;
        for (int i = 319; i >= 0; i--) begin
            if (!found && mag[i]) begin
                p = i; found = 1'b1;
            end
        end
        e = p - 22;
        if (e <= 0) return {1'b0, s, 31'd0};
        sh = p - 23;
        mant = 25'(mag >> sh);
`ifdef ADDSUB_RNE_EN
        if (sh > 0) begin
            rem  = mag & ((320'd1 << sh) - 320'd1);
            half = 320'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 25'd1;
        end
`endif
        if (mant[24]) begin
            mant = mant >> 1;
            e = e + 1;
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
        return {1'b0, s, 8'(e), mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_operand(input int base_exp);
        int          sel, ex;
        logic [22:0] f;
        sel = int'($urandom_range(0, 15));
        f   = 23'($urandom);
        case (sel)
            0: ex = 0;
            1: begin ex = 255; if ($urandom_range(0, 3) != 0) f = 23'd0; end
            2: ex = 254;
            3: ex = 1;
            default: begin
                ex = base_exp + int'($urandom_range(0, 60)) - 30;
                if (ex < 1) ex = 1;
                if (ex > 254) ex = 254;
            end
        endcase
        return {1'($urandom), 8'(ex), f};
    endfunction

    task automatic test_reset();
        n_rst = 1'b0; add_start = 1'b0; mode = 1'b0;
        op1 = 32'h3F800000; op2 = 32'h3F800000;
        repeat (2) @(negedge clk);
        tests_run++;
        if (add_result !== 32'h0) begin
            tests_failed++; $display("FAIL reset_result: got %08h expected 00000000", add_result);
        end
        tests_run++;
        if (add_done !== 1'b0) begin
            tests_failed++; $display("FAIL reset_done: got %b expected 0", add_done);
        end
        tests_run++;
        if (add_overflow !== 1'b0) begin
            tests_failed++; $display("FAIL reset_overflow: got %b expected 0", add_overflow);
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (add_result !== 32'h0 || add_done !== 1'b0 || add_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_hold: got res=%08h done=%b ovf=%b expected 00000000/0/0",
                     add_result, add_done, add_overflow);
        end
        $display("[TB] reset: res=%08h done=%b ovf=%b", add_result, add_done, add_overflow);
    endtask

    task automatic test_directed();
        for (int k = 0; k < N_DIR; k++) begin
            op1 = DIR_A[k]; op2 = DIR_B[k]; mode = DIR_M[k]; add_start = 1'b1;
            @(negedge clk);
            add_start = 1'b0;
            $display("[TB] dir %0d: %08h %s %08h -> %08h ovf=%b done=%b", k, DIR_A[k],
                     DIR_M[k] ? "-" : "+", DIR_B[k], add_result, add_overflow, add_done);
            tests_run++;
            if (add_result !== DIR_R[k]) begin
                tests_failed++; $display("FAIL dir%0d_result: got %08h expected %08h", k, add_result, DIR_R[k]);
            end
            tests_run++;
            if (add_overflow !== DIR_O[k]) begin
                tests_failed++; $display("FAIL dir%0d_overflow: got %b expected %b", k, add_overflow, DIR_O[k]);
            end
            tests_run++;
            if (add_done !== 1'b1) begin
                tests_failed++; $display("FAIL dir%0d_done: got %b expected 1", k, add_done);
            end
            op1 = 32'h12345678; op2 = 32'h42424242;
            @(negedge clk);
            tests_run++;
            if (add_done !== 1'b0 || add_result !== DIR_R[k]) begin
                tests_failed++;
                $display("FAIL dir%0d_hold: got done=%b res=%08h expected 0/%08h", k, add_done, add_result, DIR_R[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3] = '{32'h40200000, 32'h3F800000, 32'hC1200000};
        logic [31:0] b [3] = '{32'h40600000, 32'h3F800000, 32'h40A00000};
        logic [31:0] r [3] = '{32'h40C00000, 32'h40000000, 32'hC0A00000};
        add_start = 1'b1; mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            op1 = a[k]; op2 = b[k];
            @(negedge clk);
            $display("[TB] b2b %0d: %08h + %08h -> %08h done=%b", k, a[k], b[k], add_result, add_done);
            tests_run++;
            if (add_result !== r[k] || add_done !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b%0d: got res=%08h done=%b expected %08h/1", k, add_result, add_done, r[k]);
            end
        end
        add_start = 1'b0; op1 = 32'h7F7FFFFF; op2 = 32'h7F7FFFFF;
        @(negedge clk);
        tests_run++;
        if (add_done !== 1'b0 || add_result !== r[2] || add_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drop: got done=%b res=%08h ovf=%b expected 0/%08h/0",
                     add_done, add_result, add_overflow, r[2]);
        end
    endtask

    task automatic test_midstream_reset();
        op1 = 32'h7F7FFFFF; op2 = 32'h7F7FFFFF; mode = 1'b0; add_start = 1'b1;
        @(negedge clk);
        tests_run++;
        if (add_overflow !== 1'b1 || add_result !== 32'h7F800000) begin
            tests_failed++;
            $display("FAIL midrst_setup: got res=%08h ovf=%b expected 7F800000/1", add_result, add_overflow);
        end
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        tests_run++;
        if (add_result !== 32'h0 || add_done !== 1'b0 || add_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_async: got res=%08h done=%b ovf=%b expected 00000000/0/0",
                     add_result, add_done, add_overflow);
        end
        @(negedge clk);
        add_start = 1'b0;
        n_rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (add_result !== 32'h0 || add_done !== 1'b0 || add_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_after: got res=%08h done=%b ovf=%b expected 00000000/0/0",
                     add_result, add_done, add_overflow);
        end
        $display("[TB] midstream reset: res=%08h done=%b ovf=%b", add_result, add_done, add_overflow);
    endtask

    task automatic test_random(input int n);
        logic [32:0] model;
        logic [31:0] exp_res;
        logic        exp_ovf, exp_done;
        int          base;
        exp_res = 32'h0; exp_ovf = 1'b0;
        for (int k = 0; k < n; k++) begin
            base = int'($urandom_range(1, 254));
            op1  = rand_operand(base);
            op2  = rand_operand(base);
            if ($urandom_range(0, 3) == 0) op2 = {~op1[31], op1[30:4], 4'($urandom)};
            mode = 1'($urandom);
            add_start = (k == 0) || ($urandom_range(0, 3) != 0);
            if (add_start) begin
                model   = ref_addsub(op1, op2, mode);
                exp_res = model[31:0];
                exp_ovf = model[32];
            end
            exp_done = add_start;
            @(negedge clk);
            $display("[TB] rnd %0d: start=%b %08h %s %08h -> %08h ovf=%b", k, exp_done, op1,
                     mode ? "-" : "+", op2, add_result, add_overflow);
            tests_run++;
            if (add_result !== exp_res) begin
                tests_failed++; $display("FAIL rnd%0d_result: got %08h expected %08h", k, add_result, exp_res);
            end
            tests_run++;
            if (add_overflow !== exp_ovf) begin
                tests_failed++; $display("FAIL rnd%0d_overflow: got %b expected %b", k, add_overflow, exp_ovf);
            end
            tests_run++;
            if (add_done !== exp_done) begin
                tests_failed++; $display("FAIL rnd%0d_done: got %b expected %b", k, add_done, exp_done);
            end
        end
        add_start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_midstream_reset();
        test_random(400);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
